// File: rtl/sad_search_ctrl.sv
// Full-search block-match sequencer: loads a 4x4 window into the SAD datapath, streams every
// word-aligned 4x4 candidate of the frame and keeps the minimum SAD with its position.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; best_* hold previous result
// S_LOAD_WIN | reading window rows 0..3 into the datapath (k = row)
// S_FETCH  | reading candidate (row, col) rows k = 0..3; compare on k = 3
// S_DONE   | one-cycle completion pulse
module sad_search_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [ADDR_W-1:0] window_base,
    input  logic [DIM_W-1:0]  frame_rows,
    input  logic [DIM_W-1:0]  frame_words,
    output logic [ADDR_W-1:0] MEM_SAD_Address,
    output logic              MEM_SAD_Read,
    output logic              frame_shift,
    output logic              window_shift,
    input  logic [31:0]       SAD_value,
    output logic              busy,
    output logic              done,
    output logic              best_valid,
    output logic [31:0]       best_sad,
    output logic [DIM_W-1:0]  best_row,
    output logic [DIM_W-1:0]  best_col
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD_WIN, S_FETCH, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_k;
    logic [DIM_W-1:0]  r_row;
    logic [DIM_W-1:0]  r_col;
    logic [DIM_W-1:0]  r_rows;
    logic [DIM_W-1:0]  r_words;
    logic [ADDR_W-1:0] r_win_base;
    logic [ADDR_W-1:0] r_pitch;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_cand_base;
    logic [ADDR_W-1:0] r_addr;
    logic              r_best_valid;
    logic [31:0]       r_best_sad;
    logic [DIM_W-1:0]  r_best_row;
    logic [DIM_W-1:0]  r_best_col;

    logic              w_degenerate;
    logic              w_k_last;
    logic              w_last_col;
    logic              w_last_row;
    logic [ADDR_W-1:0] w_next_row_base;

    assign w_degenerate    = (frame_rows < DIM_W'(4)) || (frame_words == '0);
    assign w_k_last        = (r_k == 2'd3);
    assign w_last_col      = (r_col == r_words - DIM_W'(1));
    assign w_last_row      = (r_row == r_rows - DIM_W'(4));
    assign w_next_row_base = r_row_base + r_pitch;

    assign best_valid = r_best_valid;
    assign best_sad   = r_best_sad;
    assign best_row   = r_best_row;
    assign best_col   = r_best_col;

    always_comb begin
        w_state_nxt     = r_state;
        MEM_SAD_Address = '0;
        MEM_SAD_Read    = 1'b0;
        frame_shift     = 1'b0;
        window_shift    = 1'b0;
        busy            = (r_state != S_IDLE);
        done            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_state_nxt = w_degenerate ? S_DONE : S_LOAD_WIN;
            end
            S_LOAD_WIN: begin
                MEM_SAD_Address = r_win_base + ADDR_W'({r_k, 2'b00});
                MEM_SAD_Read    = 1'b1;
                window_shift    = 1'b1;
                if (w_k_last)
                    w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                MEM_SAD_Address = r_addr;
                MEM_SAD_Read    = 1'b1;
                // Row 3 is consumed live from the read data, so it is not shifted in.
                frame_shift     = !w_k_last;
                if (w_k_last && w_last_row && w_last_col)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_rows       <= '0;
            r_words      <= '0;
            r_win_base   <= '0;
            r_pitch      <= '0;
            r_row_base   <= '0;
            r_cand_base  <= '0;
            r_addr       <= '0;
            r_best_valid <= 1'b0;
            r_best_sad   <= '1;
            r_best_row   <= '0;
            r_best_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_k          <= '0;
                        r_row        <= '0;
                        r_col        <= '0;
                        r_rows       <= frame_rows;
                        r_words      <= frame_words;
                        r_win_base   <= window_base;
                        r_pitch      <= ADDR_W'({frame_words, 2'b00});
                        r_row_base   <= frame_base;
                        r_cand_base  <= frame_base;
                        r_addr       <= frame_base;
                        r_best_valid <= 1'b0;
                        r_best_sad   <= '1;
                    end
                end
                S_LOAD_WIN: begin
                    r_k <= r_k + 2'd1;
                end
                S_FETCH: begin
                    r_k <= r_k + 2'd1;
                    if (!w_k_last) begin
                        r_addr <= r_addr + r_pitch;
                    end else begin
                        if (SAD_value < r_best_sad) begin
                            r_best_sad   <= SAD_value;
                            r_best_row   <= r_row;
                            r_best_col   <= r_col;
                            r_best_valid <= 1'b1;
                        end
                        if (w_last_col) begin
                            r_col       <= '0;
                            r_row       <= r_row + DIM_W'(1);
                            r_row_base  <= w_next_row_base;
                            r_cand_base <= w_next_row_base;
                            r_addr      <= w_next_row_base;
                        end else begin
                            r_col       <= r_col + DIM_W'(1);
                            r_cand_base <= r_cand_base + ADDR_W'(4);
                            r_addr      <= r_cand_base + ADDR_W'(4);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
